// File: rtl/instr_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_pkg
// Definitions shared by the fetch, decode and execute stages of the
// segmented processor:
//   - opcode encodings (jump, nop, load word, store word)
//   - the bubble instruction word NOP_INSTR
//   - the fetch FSM state type {RUN, FAULT}
//   - a helper that recognises a relative-jump word
// No ports (package).
// -----------------------------------------------------------------------------
package instr_fetch_unit_pkg;

    localparam logic [5:0] OPC_JUMP = 6'b111110;
    localparam logic [5:0] OPC_NOP  = 6'b111111;
    localparam logic [5:0] OPC_LW   = 6'b100011;
    localparam logic [5:0] OPC_SW   = 6'b101011;

    // Bubble word: NOP opcode with an all-zero payload.
    localparam logic [31:0] NOP_INSTR = {OPC_NOP, 26'd0};

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    function automatic logic is_jump_word(input logic [31:0] word);
        return word[31:26] == OPC_JUMP;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_ifid.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_ifid (module ifid_reg)
// IF/ID pipeline register with hold and flush controls.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   hold                  keep current contents (decode stall)
//   flush                 load a bubble {NOP_INSTR, pc 0, valid 0}; beats hold
//   instr_in, pc_in       instruction word and its PC to capture
//   instr, pc, valid      registered IF/ID contents
// Priority on each edge: reset, flush, hold, load.
// -----------------------------------------------------------------------------
module ifid_reg
    import instr_fetch_unit_pkg::*;
#(
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] NOP_WORD  = instr_fetch_unit_pkg::NOP_INSTR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic              flush,
    input  logic [31:0]       instr_in,
    input  logic [ADDR_W-1:0] pc_in,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] pc,
    output logic              valid
);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            instr <= NOP_WORD;
            pc    <= '0;
            valid <= 1'b0;
        end else if (!hold) begin
            instr <= instr_in;
            pc    <= pc_in;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Initiator side of the instruction-memory interface. Owns the PC, drives the
// word address to the ROM, folds unconditional relative jumps in fetch at zero
// penalty, accepts EX redirects, honours decode back-pressure and flags fetches
// that leave the ROM range.
//
// Optional build macro: FETCH_PERF_CNT_EN adds perf_fetched / perf_stalls.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   direinstru        word address to ROM (combinational copy of PC)
//   instru            ROM word for direinstru (zero-latency read)
//   id_ready          decode accepts a new IF/ID entry this cycle
//   redirect_valid    EX branch taken / flush request
//   redirect_pc       redirect target word address
//   ifid_instr/pc/valid  registered IF/ID contents
//   fetch_fault       sticky out-of-range flag (high while in FAULT)
//   perf_fetched      (optional) count of cycles ifid_valid is loaded with 1
//   perf_stalls       (optional) count of RUN cycles with !id_ready && !redirect_valid
//
// Handshake: decode takes the IF/ID entry on an edge where id_ready is high;
// while id_ready is low the entry and PC hold. A redirect always flushes,
// regardless of id_ready.
// -----------------------------------------------------------------------------
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                ROM_DEPTH = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [31:0]       NOP_INSTR = instr_fetch_unit_pkg::NOP_INSTR
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] direinstru,
    input  logic [31:0]       instru,
    input  logic              id_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [31:0]       ifid_instr,
    output logic [ADDR_W-1:0] ifid_pc,
    output logic              ifid_valid,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stalls,
`endif
    output logic              fetch_fault
);

    localparam logic [ADDR_W-1:0] ROM_LIMIT = ADDR_W'(ROM_DEPTH);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              ifid_flush, ifid_hold;
    logic              pc_oob, is_jump;
    logic [ADDR_W-1:0] jump_target;

    assign direinstru  = pc_q;
    assign pc_oob      = (pc_q >= ROM_LIMIT);
    assign is_jump     = is_jump_word(instru);
    // 26-bit signed offset, extended to ADDR_W; the sum wraps modulo 2^ADDR_W.
    assign jump_target = pc_q + ADDR_W'($signed(instru[25:0]));

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                // A range check only fires on a real fetch: not on a flush
                // and not while decode is stalling.
                if (!redirect_valid && id_ready && pc_oob) begin
                    state_d = FAULT;
                end
            end
            FAULT: begin
                if (redirect_valid) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // ---------------- output / datapath control ----------------
    always_comb begin
        pc_d       = pc_q;
        ifid_flush = 1'b0;
        ifid_hold  = 1'b0;
        case (state_q)
            RUN: begin
                if (redirect_valid) begin
                    pc_d       = redirect_pc;
                    ifid_flush = 1'b1;
                end else if (!id_ready) begin
                    ifid_hold  = 1'b1;
                end else if (pc_oob) begin
                    ifid_flush = 1'b1;
                end else if (is_jump) begin
                    // The jump is consumed here and never reaches decode.
                    pc_d       = jump_target;
                    ifid_flush = 1'b1;
                end else begin
                    pc_d       = pc_q + ADDR_W'(1);
                end
            end
            FAULT: begin
                ifid_flush = 1'b1;
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end
            end
            default: ifid_flush = 1'b1;
        endcase
    end

    assign fetch_fault = (state_q == FAULT);

    // ---------------- program counter ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // ---------------- IF/ID register ----------------
    ifid_reg #(
        .ADDR_W   (ADDR_W),
        .NOP_WORD (NOP_INSTR)
    ) u_ifid (
        .clk      (clk),
        .reset    (reset),
        .hold     (ifid_hold),
        .flush    (ifid_flush),
        .instr_in (instru),
        .pc_in    (pc_q),
        .instr    (ifid_instr),
        .pc       (ifid_pc),
        .valid    (ifid_valid)
    );

`ifdef FETCH_PERF_CNT_EN
    logic ifid_load;
    logic stall_cycle;

    assign ifid_load   = !ifid_flush && !ifid_hold;
    assign stall_cycle = (state_q == RUN) && !id_ready && !redirect_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_stalls  <= '0;
        end else begin
            if (ifid_load) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (stall_cycle) begin
                perf_stalls <= perf_stalls + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Bench for instr_fetch_unit with a behavioural 32-word ROM.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the
// same point, so every sample reflects the edge just taken.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam int          ADDR_W = 32;
    localparam logic [31:0] NOP_W  = 32'hFC00_0000;
    localparam logic [64:0] BUBBLE = {1'b0, 32'd0, NOP_W};

    logic              clk;
    logic              reset;
    logic [ADDR_W-1:0] direinstru;
    logic [31:0]       instru;
    logic              id_ready;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic [31:0]       ifid_instr;
    logic [ADDR_W-1:0] ifid_pc;
    logic              ifid_valid;
    logic              fetch_fault;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]       perf_fetched;
    logic [31:0]       perf_stalls;
`endif

    logic [31:0] rom [0:31];
    logic [64:0] exp_q[$];
    logic [64:0] got, exp_v;
    int tests_run;
    int tests_failed;

    assign instru = (direinstru < 32) ? rom[direinstru[4:0]] : 32'hDEAD_BEEF;

    instr_fetch_unit #(
        .ADDR_W    (32),
        .ROM_DEPTH (32),
        .RESET_PC  (32'd0),
        .NOP_INSTR (32'hFC00_0000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .direinstru     (direinstru),
        .instru         (instru),
        .id_ready       (id_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ifid_instr     (ifid_instr),
        .ifid_pc        (ifid_pc),
        .ifid_valid     (ifid_valid),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetched   (perf_fetched),
        .perf_stalls    (perf_stalls),
`endif
        .fetch_fault    (fetch_fault)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_ready       = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic init_rom();
        for (int i = 0; i < 32; i++) begin
            rom[i] = 32'h0100_0000 + 32'(i) * 32'h11;
        end
    endtask

    function automatic logic [64:0] entry(input int k);
        return {1'b1, 32'(k), rom[k]};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        reset          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'd13;
        id_ready       = 1'b0;
        exp_q.push_back(BUBBLE);
        tick();
        reset = 1'b0; redirect_valid = 1'b0; id_ready = 1'b1;
        got = {ifid_valid, ifid_pc, ifid_instr};
        exp_v = exp_q.pop_front();
        tests_run++;
        if (got !== exp_v) begin
            tests_failed++;
            $display("FAIL reset_ifid: got %h expected %h", got, exp_v);
        end
        tests_run++;
        if (direinstru !== 32'd0 || fetch_fault !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_pc_fault: got pc %0d fault %b expected pc 0 fault 0", direinstru, fetch_fault);
        end
    endtask

    task automatic test_sequential();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (direinstru !== 32'(k)) begin
                tests_failed++;
                $display("FAIL seq_addr: got %0d expected %0d", direinstru, k);
            end
            exp_q.push_back(entry(k));
            tick();
            got = {ifid_valid, ifid_pc, ifid_instr};
            exp_v = exp_q.pop_front();
            tests_run++;
            if (got !== exp_v) begin
                tests_failed++;
                $display("FAIL seq_ifid: got %h expected %h", got, exp_v);
            end
        end
    endtask

    task automatic test_jump();
        int addr_seq [8] = '{0, 1, 2, 4, 5, 6, 3, 4};
        bit bubble_seq [8] = '{0, 0, 1, 0, 0, 1, 0, 0};
        rom[2] = 32'hF800_0002;  // jump +2
        rom[6] = 32'hFBFF_FFFD;  // jump -3
        do_reset();
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (direinstru !== 32'(addr_seq[i])) begin
                tests_failed++;
                $display("FAIL jump_addr: step %0d got %0d expected %0d", i, direinstru, addr_seq[i]);
            end
            exp_q.push_back(bubble_seq[i] ? BUBBLE : entry(addr_seq[i]));
            tick();
            got = {ifid_valid, ifid_pc, ifid_instr};
            exp_v = exp_q.pop_front();
            tests_run++;
            if (got !== exp_v) begin
                tests_failed++;
                $display("FAIL jump_ifid: step %0d got %h expected %h", i, got, exp_v);
            end
        end
        init_rom();
    endtask

    task automatic test_stall();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back(entry(k));
            tick();
            got = {ifid_valid, ifid_pc, ifid_instr};
            exp_v = exp_q.pop_front();
            tests_run++;
            if (got !== exp_v) begin
                tests_failed++;
                $display("FAIL stall_pre_ifid: got %h expected %h", got, exp_v);
            end
        end
        id_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) id_ready = 1'b1;
            tests_run++;
            if (direinstru !== 32'd5) begin
                tests_failed++;
                $display("FAIL stall_addr: cycle %0d got %0d expected 5", i, direinstru);
            end
            exp_q.push_back((i == 3) ? entry(5) : entry(4));
            tick();
            got = {ifid_valid, ifid_pc, ifid_instr};
            exp_v = exp_q.pop_front();
            tests_run++;
            if (got !== exp_v) begin
                tests_failed++;
                $display("FAIL stall_ifid: cycle %0d got %h expected %h", i, got, exp_v);
            end
        end
        tests_run++;
        if (direinstru !== 32'd6) begin
            tests_failed++;
            $display("FAIL stall_resume_addr: got %0d expected 6", direinstru);
        end
    endtask

    task automatic test_flush_beats_stall();
        id_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'd7;
        exp_q.push_back(BUBBLE);
        tick();
        redirect_valid = 1'b0; id_ready = 1'b1;
        tests_run++;
        if (direinstru !== 32'd7) begin
            tests_failed++;
            $display("FAIL flush_addr: got %0d expected 7", direinstru);
        end
        for (int i = 0; i < 2; i++) begin
            if (i == 0) begin
                got = {ifid_valid, ifid_pc, ifid_instr};
            end else begin
                exp_q.push_back(entry(7));
                tick();
                got = {ifid_valid, ifid_pc, ifid_instr};
            end
            exp_v = exp_q.pop_front();
            tests_run++;
            if (got !== exp_v) begin
                tests_failed++;
                $display("FAIL flush_ifid: step %0d got %h expected %h", i, got, exp_v);
            end
        end
        tests_run++;
        if (direinstru !== 32'd8) begin
            tests_failed++;
            $display("FAIL flush_next_addr: got %0d expected 8", direinstru);
        end
    endtask

    task automatic test_fault();
        // step: redirect?, target, id_ready, expected pc after, expected fault after
        bit   rv   [6] = '{1, 0, 0, 0, 1, 0};
        int   tgt  [6] = '{32, 0, 0, 0, 0, 0};
        bit   rdy  [6] = '{1, 1, 0, 1, 1, 1};
        int   epc  [6] = '{32, 32, 32, 32, 0, 1};
        bit   eflt [6] = '{0, 1, 1, 1, 0, 0};
        for (int i = 0; i < 6; i++) begin
            redirect_valid = rv[i];
            redirect_pc    = 32'(tgt[i]);
            id_ready       = rdy[i];
            exp_q.push_back((i == 5) ? entry(0) : BUBBLE);
            tick();
            redirect_valid = 1'b0;
            id_ready       = 1'b1;
            got = {ifid_valid, ifid_pc, ifid_instr};
            exp_v = exp_q.pop_front();
            tests_run++;
            if (got !== exp_v) begin
                tests_failed++;
                $display("FAIL fault_ifid: step %0d got %h expected %h", i, got, exp_v);
            end
            tests_run++;
            if (direinstru !== 32'(epc[i]) || fetch_fault !== eflt[i]) begin
                tests_failed++;
                $display("FAIL fault_state: step %0d got pc %0d fault %b expected pc %0d fault %b",
                         i, direinstru, fetch_fault, epc[i], eflt[i]);
            end
        end
    endtask

    task automatic test_halt_loop();
        rom[3] = 32'hF800_0000;  // jump +0
        do_reset();
        for (int k = 0; k < 6; k++) begin
            tests_run++;
            if (direinstru !== 32'((k < 3) ? k : 3)) begin
                tests_failed++;
                $display("FAIL halt_addr: step %0d got %0d expected %0d", k, direinstru, (k < 3) ? k : 3);
            end
            exp_q.push_back((k < 3) ? entry(k) : BUBBLE);
            tick();
            got = {ifid_valid, ifid_pc, ifid_instr};
            exp_v = exp_q.pop_front();
            tests_run++;
            if (got !== exp_v) begin
                tests_failed++;
                $display("FAIL halt_ifid: step %0d got %h expected %h", k, got, exp_v);
            end
        end
        init_rom();
    endtask

    task automatic test_reset_mid();
        // rst, redirect?, target, id_ready, expected pc after, expected fault after
        bit rst  [6] = '{0, 1, 0, 0, 0, 1};
        bit rv   [6] = '{1, 1, 0, 1, 0, 1};
        int tgt  [6] = '{9, 20, 0, 40, 0, 5};
        bit rdy  [6] = '{1, 0, 1, 1, 1, 0};
        int epc  [6] = '{9, 0, 1, 40, 40, 0};
        bit eflt [6] = '{0, 0, 0, 0, 1, 0};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            reset          = rst[i];
            redirect_valid = rv[i];
            redirect_pc    = 32'(tgt[i]);
            id_ready       = rdy[i];
            exp_q.push_back((i == 2) ? entry(0) : BUBBLE);
            tick();
            reset = 1'b0; redirect_valid = 1'b0; id_ready = 1'b1;
            got = {ifid_valid, ifid_pc, ifid_instr};
            exp_v = exp_q.pop_front();
            tests_run++;
            if (got !== exp_v) begin
                tests_failed++;
                $display("FAIL reset_mid_ifid: step %0d got %h expected %h", i, got, exp_v);
            end
            tests_run++;
            if (direinstru !== 32'(epc[i]) || fetch_fault !== eflt[i]) begin
                tests_failed++;
                $display("FAIL reset_mid_state: step %0d got pc %0d fault %b expected pc %0d fault %b",
                         i, direinstru, fetch_fault, epc[i], eflt[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int pc_m;
        logic [64:0] last;
        do_reset();
        pc_m = 0;
        last = BUBBLE;
        for (int i = 0; i < 80 && pc_m < 24; i++) begin
            id_ready = ($urandom_range(0, 3) != 0);
            tests_run++;
            if (direinstru !== 32'(pc_m)) begin
                tests_failed++;
                $display("FAIL b2b_addr: cycle %0d got %0d expected %0d", i, direinstru, pc_m);
            end
            if (id_ready) begin
                last = entry(pc_m);
                pc_m++;
            end
            exp_q.push_back(last);
            tick();
            got = {ifid_valid, ifid_pc, ifid_instr};
            exp_v = exp_q.pop_front();
            tests_run++;
            if (got !== exp_v) begin
                tests_failed++;
                $display("FAIL b2b_ifid: cycle %0d got %h expected %h", i, got, exp_v);
            end
        end
        id_ready = 1'b1;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        reset          = 1'b1;
        id_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        init_rom();
        #1;
        test_reset();
        test_sequential();
        test_jump();
        test_stall();
        test_flush_beats_stall();
        test_fault();
        test_halt_loop();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
